mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock, CLK, and a synchronous active-high reset, RESET; no other clock or reset exists.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 64: the maximum number of cycles spent in a busy state before abort (used only with MEM_ARB_TIMEOUT_EN).
REQ-003 The block SHALL have the following ports:
- CLK  in  1  clock
- RESET  in  1  synchronous reset, active-high
- IF_REQ  in  1  instruction fetch request, held until IF_READY
- IF_ADDR  in  32  fetch address
- IF_RDATA  out  32  fetch read data, valid while IF_READY=1
- IF_READY  out  1  one-cycle completion pulse for fetch
- DM_REQ  in  1  data request, held until DM_READY
- DM_ADDR  in  32  data address
- DM_WDATA  in  32  store data
- DM_RW  in  4  access code (4'b0000 = none; bit3=1 store, bit3=0 load)
- DM_RDATA  out  32  load data, valid while DM_READY=1
- DM_READY  out  1  one-cycle completion pulse for data
- MEM_REQ  out  1  request to the shared single-port memory
- MEM_ADDR  out  32  memory address
- MEM_WDATA  out  32  memory write data
- MEM_RW  out  4  access code to memory
- MEM_RDATA  in  32  memory read data, valid with MEM_ACK
- MEM_ACK  in  1  memory completion, one cycle
- STALL_IF  out  1  IF_REQ & ~IF_READY
- STALL_DM  out  1  DM_REQ & ~DM_READY
- ERR  out  1  timeout abort pulse

Function
REQ-004 The FSM SHALL have the states IDLE, IF_BUSY and DM_BUSY, with a registered state.
REQ-005 In IDLE, a request counts only when its REQ is asserted, IF_READY/DM_READY is not asserted for that requester this cycle, and, for data, DM_RW != 0; a DM_REQ with DM_RW=0 SHALL complete with DM_READY on the next cycle without any memory access.
REQ-006 Conflict (both requesters valid) SHALL be resolved by the register LAST_GNT: the requester not served last is granted; LAST_GNT SHALL update on every grant.
REQ-007 On a grant, address, write data and RW SHALL be latched; MEM_REQ=1 and the latched values SHALL drive MEM_* from the cycle after the request is sampled until MEM_ACK is sampled.
REQ-008 For an IF grant, MEM_RW SHALL be 4'b0001 (word load), MEM_WDATA SHALL be 0, and LAST_GNT SHALL be set to IF; for a DM grant, MEM_RW SHALL be the latched DM_RW.
REQ-009 On the edge where MEM_ACK=1 in a busy state: the FSM SHALL go to IDLE; the matching READY SHALL be 1 for exactly the next cycle; the matching RDATA SHALL register MEM_RDATA (0 for stores) and hold until the next completion.
REQ-010 Minimum latency SHALL be request sampled in cycle N, MEM_REQ in N+1, ACK in N+1, READY in N+2, next grant sampled in N+2.
REQ-011 MEM_ACK in IDLE SHALL be ignored.
REQ-012 MEM_REQ SHALL never be asserted for two masters at once, and the latched MEM_* values SHALL NOT change while MEM_REQ=1.

Reset
REQ-013 On RESET the block SHALL set: state=IDLE, LAST_GNT=IF, MEM_REQ=0, MEM_ADDR/MEM_WDATA/MEM_RW=0, IF_RDATA/DM_RDATA=0, IF_READY/DM_READY=0, ERR=0, timeout counter=0.
REQ-014 On RESET mid-transaction, MEM_REQ SHALL drop in the cycle after the reset edge, no READY SHALL be issued, and a late MEM_ACK SHALL be ignored.

Configuration
REQ-015 With MEM_ARB_TIMEOUT_EN defined: a counter SHALL clear on grant and increment each busy cycle; on reaching TIMEOUT_CYCLES without ACK, the FSM SHALL go to IDLE and the matching READY and ERR SHALL pulse together for one cycle with RDATA=0.
REQ-016 Without MEM_ARB_TIMEOUT_EN: the block SHALL wait indefinitely for ACK, ERR SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-017 The package cpu_mem_pkg SHALL hold the state encoding, the grant IDs (GNT_IF, GNT_DM), the RW codes (RW_NONE=4'b0000, RW_LW=4'b0001) and the store-bit index.
REQ-018 One sub-module SHALL exist, mem_arb_timer (counter plus compare), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-019 Single fetch: IF_REQ, IF_ADDR=0x100, ACK after 2 cycles with 0x00000013 -> MEM_ADDR=0x100 and MEM_RW=0001, then IF_READY pulse with IF_RDATA=0x00000013.
REQ-020 Conflict after reset: IF_REQ and DM_REQ (load 0x2000) in the same cycle -> DM granted first; IF granted on the cycle after DM_READY; STALL_IF high throughout.
REQ-021 Back-to-back conflicts: both held for 4 transactions -> grant order DM, IF, DM, IF.
REQ-022 Store: DM_RW=1xxx, DM_WDATA=0xDEADBEEF, addr 0x40 -> MEM_WDATA=0xDEADBEEF stable until ACK, then DM_READY with DM_RDATA=0.
REQ-023 RESET asserted in DM_BUSY, ACK arriving 1 cycle later -> MEM_REQ=0, no DM_READY, state IDLE.
REQ-024 Timeout (macro on, TIMEOUT_CYCLES=4): no ACK -> DM_READY and ERR pulse together 4 cycles after grant, DM_RDATA=0.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and encodings for the instruction/data memory port arbiter.
// Combinational only (types, constants, one helper function).
// No flow control of its own.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_DM_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

  localparam logic [3:0] RW_NONE      = 4'b0000;
  localparam logic [3:0] RW_LW        = 4'b0001;
  localparam int         RW_STORE_BIT = 3;

  // Access codes with the store bit set never return read data.
  function automatic logic rw_is_store(input logic [3:0] rw);
    return rw[RW_STORE_BIT];
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle watchdog: counts cycles a transaction waits for its memory ack.
// expired is combinational from the count: high in the TIMEOUT_CYCLES-th busy cycle.
// No handshake; the arbiter clears it on every grant.
module mem_arb_timer
  import cpu_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic busy,
  output logic expired
);

  localparam int unsigned   CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  assign expired = busy && (count_q == LIMIT);

  // Count busy cycles since the last grant; stop once the limit is reached.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (busy && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master (fetch / data) arbiter onto one single-port memory; MEM_ARB_TIMEOUT_EN adds a busy watchdog.
// Latency: request sampled N, MEM_REQ from N+1, ack in N+1 gives READY in N+2.
// Requesters hold REQ until their one-cycle READY; memory stalls by withholding MEM_ACK.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic [31:0] IF_RDATA,
  output logic        IF_READY,
  input  logic        DM_REQ,
  input  logic [31:0] DM_ADDR,
  input  logic [31:0] DM_WDATA,
  input  logic [3:0]  DM_RW,
  output logic [31:0] DM_RDATA,
  output logic        DM_READY,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_RW,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic        STALL_IF,
  output logic        STALL_DM,
  output logic        ERR
);

  arb_state_t  state_q, state_d;
  gnt_t        last_gnt_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_rw_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        if_ready_q;
  logic        dm_ready_q;

  logic        if_valid;
  logic        dm_valid;
  logic        dm_null;
  logic        grant_if;
  logic        grant_dm;
  logic        busy;
  logic        done;
  logic        timeout;

  // A requester in its READY cycle still shows REQ; it must not be re-granted.
  assign if_valid = IF_REQ && !if_ready_q;
  assign dm_valid = DM_REQ && !dm_ready_q && (DM_RW != RW_NONE);
  // A data request with no access code completes without touching memory.
  assign dm_null  = (state_q == ST_IDLE) && DM_REQ && !dm_ready_q && (DM_RW == RW_NONE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = busy && (MEM_ACK || timeout);

`ifdef MEM_ARB_TIMEOUT_EN
  logic err_q;

  mem_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (CLK),
    .reset  (RESET),
    .clear  (grant_if || grant_dm),
    .busy   (busy),
    .expired(timeout)
  );

  // Abort flag pulses alongside READY when the watchdog ends a transaction.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout && !MEM_ACK;
    end
  end

  assign ERR = err_q;
`else
  assign timeout = 1'b0;
  assign ERR     = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant selection in IDLE (alternate on conflict) and return to IDLE on completion.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_valid && dm_valid) begin
          if (last_gnt_q == GNT_IF) begin
            grant_dm = 1'b1;
          end else begin
            grant_if = 1'b1;
          end
        end else begin
          grant_if = if_valid;
          grant_dm = dm_valid;
        end
        if (grant_if) begin
          state_d = ST_IF_BUSY;
        end else if (grant_dm) begin
          state_d = ST_DM_BUSY;
        end
      end
      ST_IF_BUSY, ST_DM_BUSY: begin
        if (done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the granted access, hold it on MEM_* until completion, capture read data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_gnt_q  <= GNT_IF;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rw_q    <= RW_NONE;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      if_ready_q <= done && (state_q == ST_IF_BUSY);
      dm_ready_q <= (done && (state_q == ST_DM_BUSY)) || dm_null;

      if (grant_if) begin
        mem_req_q   <= 1'b1;
        mem_addr_q  <= IF_ADDR;
        mem_wdata_q <= '0;
        mem_rw_q    <= RW_LW;
        last_gnt_q  <= GNT_IF;
      end else if (grant_dm) begin
        mem_req_q   <= 1'b1;
        mem_addr_q  <= DM_ADDR;
        mem_wdata_q <= DM_WDATA;
        mem_rw_q    <= DM_RW;
        last_gnt_q  <= GNT_DM;
      end else if (done) begin
        mem_req_q <= 1'b0;
      end

      // An aborted transaction returns zero data.
      if (done && (state_q == ST_IF_BUSY)) begin
        if_rdata_q <= MEM_ACK ? MEM_RDATA : '0;
      end

      if (done && (state_q == ST_DM_BUSY)) begin
        dm_rdata_q <= (MEM_ACK && !rw_is_store(mem_rw_q)) ? MEM_RDATA : '0;
      end else if (dm_null) begin
        dm_rdata_q <= '0;
      end
    end
  end

  assign MEM_REQ   = mem_req_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign MEM_RW    = mem_rw_q;
  assign IF_RDATA  = if_rdata_q;
  assign DM_RDATA  = dm_rdata_q;
  assign IF_READY  = if_ready_q;
  assign DM_READY  = dm_ready_q;
  assign STALL_IF  = IF_REQ && !if_ready_q;
  assign STALL_DM  = DM_REQ && !dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester drivers, a memory responder and a monitor.
// Expected grants are queued when stimulus is issued and retired as MEM_REQ/READY appear.
// With MEM_ARB_TIMEOUT_EN defined the watchdog scenario replaces the indefinite-wait one.
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  logic        CLK;
  logic        RESET;
  logic        IF_REQ;
  logic [31:0] IF_ADDR;
  logic [31:0] IF_RDATA;
  logic        IF_READY;
  logic        DM_REQ;
  logic [31:0] DM_ADDR;
  logic [31:0] DM_WDATA;
  logic [3:0]  DM_RW;
  logic [31:0] DM_RDATA;
  logic        DM_READY;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_RW;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;
  logic        STALL_IF;
  logic        STALL_DM;
  logic        ERR;

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_READY(IF_READY),
    .DM_REQ(DM_REQ), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA), .DM_RW(DM_RW),
    .DM_RDATA(DM_RDATA), .DM_READY(DM_READY),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RW(MEM_RW),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .STALL_IF(STALL_IF), .STALL_DM(STALL_DM), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        dm;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  rw;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  rw;
  } dm_cmd_t;

  txn_t        exp_q[$];
  logic [31:0] if_resp_q[$];
  logic [31:0] dm_resp_q[$];
  logic [31:0] if_cmd_q[$];
  dm_cmd_t     dm_cmd_q[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int ack_delay    = 0;
  bit resp_en      = 1'b1;
  bit force_ack    = 1'b0;
  bit flush        = 1'b0;
  bit timeout_mode = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return ~a ^ 32'h0F0F_0000;
  endfunction

  // Memory model: acknowledges after ack_delay waiting cycles, data from mem_word.
  initial begin
    int cnt;
    cnt = 0;
    MEM_ACK = 1'b0;
    MEM_RDATA = '0;
    forever begin
      @(negedge CLK);
      MEM_ACK = force_ack;
      if (force_ack) MEM_RDATA = 32'hBAD0_0000;
      if (MEM_REQ && resp_en) begin
        if (cnt >= ack_delay) begin
          MEM_ACK = 1'b1;
          MEM_RDATA = mem_word(MEM_ADDR);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Fetch requester: holds IF_REQ until IF_READY, then takes the next queued address.
  initial begin
    IF_REQ = 1'b0;
    IF_ADDR = '0;
    forever begin
      @(posedge CLK); #1;
      if (flush) begin
        IF_REQ = 1'b0;
        if_cmd_q.delete();
      end else if (IF_REQ && IF_READY) begin
        if (if_cmd_q.size() > 0) IF_ADDR = if_cmd_q.pop_front();
        else IF_REQ = 1'b0;
      end else if (!IF_REQ && if_cmd_q.size() > 0) begin
        IF_ADDR = if_cmd_q.pop_front();
        IF_REQ = 1'b1;
      end
    end
  end

  // Data requester: same protocol as fetch, carrying RW code and store data.
  initial begin
    dm_cmd_t c;
    DM_REQ = 1'b0;
    DM_ADDR = '0;
    DM_WDATA = '0;
    DM_RW = RW_NONE;
    forever begin
      @(posedge CLK); #1;
      if (flush) begin
        DM_REQ = 1'b0;
        dm_cmd_q.delete();
      end else if ((DM_REQ && DM_READY) || (!DM_REQ && dm_cmd_q.size() > 0)) begin
        if (dm_cmd_q.size() > 0) begin
          c = dm_cmd_q.pop_front();
          DM_ADDR = c.addr;
          DM_WDATA = c.wdata;
          DM_RW = c.rw;
          DM_REQ = 1'b1;
        end else begin
          DM_REQ = 1'b0;
        end
      end
    end
  end

  // Monitor: retires expected grants and completions, checks MEM_* stability and ERR.
  initial begin
    logic        prev_req;
    txn_t        t;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_rw;
    logic [31:0] r;
    prev_req = 1'b0;
    s_addr = '0;
    s_wdata = '0;
    s_rw = '0;
    forever begin
      @(negedge CLK);
      if (MEM_REQ && !prev_req) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_grant: MEM_ADDR=%h MEM_RW=%b, expected no grant", MEM_ADDR, MEM_RW);
        end else begin
          t = exp_q.pop_front();
          if (MEM_ADDR !== t.addr || MEM_RW !== t.rw || MEM_WDATA !== t.wdata) begin
            tests_failed++;
            $display("FAIL grant_fields: addr=%h rw=%b wdata=%h, expected addr=%h rw=%b wdata=%h",
                     MEM_ADDR, MEM_RW, MEM_WDATA, t.addr, t.rw, t.wdata);
          end
          if (t.dm) dm_resp_q.push_back(t.rdata);
          else if_resp_q.push_back(t.rdata);
        end
        s_addr = MEM_ADDR;
        s_wdata = MEM_WDATA;
        s_rw = MEM_RW;
      end else if (MEM_REQ && prev_req) begin
        tests_run++;
        if (MEM_ADDR !== s_addr || MEM_WDATA !== s_wdata || MEM_RW !== s_rw) begin
          tests_failed++;
          $display("FAIL mem_stable: addr=%h wdata=%h rw=%b, expected addr=%h wdata=%h rw=%b",
                   MEM_ADDR, MEM_WDATA, MEM_RW, s_addr, s_wdata, s_rw);
        end
      end
      if (IF_READY) begin
        tests_run++;
        if (if_resp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_if_ready: IF_READY=1 IF_RDATA=%h, expected no completion", IF_RDATA);
        end else begin
          r = if_resp_q.pop_front();
          if (IF_RDATA !== r) begin
            tests_failed++;
            $display("FAIL if_rdata: got %h expected %h", IF_RDATA, r);
          end
        end
      end
      if (DM_READY) begin
        tests_run++;
        if (dm_resp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_dm_ready: DM_READY=1 DM_RDATA=%h, expected no completion", DM_RDATA);
        end else begin
          r = dm_resp_q.pop_front();
          if (DM_RDATA !== r) begin
            tests_failed++;
            $display("FAIL dm_rdata: got %h expected %h", DM_RDATA, r);
          end
        end
      end
      if (!timeout_mode) begin
        tests_run++;
        if (ERR !== 1'b0) begin
          tests_failed++;
          $display("FAIL err_idle: ERR=%b expected 0", ERR);
        end
      end
      prev_req = MEM_REQ;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion within 400us");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset();
    @(negedge CLK);
    RESET = 1'b1;
    flush = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    flush = 1'b0;
    exp_q.delete();
    if_resp_q.delete();
    dm_resp_q.delete();
  endtask

  task automatic wait_drain(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && if_resp_q.size() == 0 && dm_resp_q.size() == 0 &&
          if_cmd_q.size() == 0 && dm_cmd_q.size() == 0 && !IF_REQ && !DM_REQ && !MEM_REQ) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    tests_run++;
    if ({MEM_REQ, IF_READY, DM_READY, ERR} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: MEM_REQ/IF_READY/DM_READY/ERR=%b expected 0000", {MEM_REQ, IF_READY, DM_READY, ERR});
    end
    tests_run++;
    if (MEM_ADDR !== 32'h0 || MEM_WDATA !== 32'h0 || MEM_RW !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_mem: addr=%h wdata=%h rw=%b expected all zero", MEM_ADDR, MEM_WDATA, MEM_RW);
    end
    tests_run++;
    if (IF_RDATA !== 32'h0 || DM_RDATA !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata: if=%h dm=%h expected 0 and 0", IF_RDATA, DM_RDATA);
    end
    RESET = 1'b0;
  endtask

  task automatic test_single_fetch();
    bit ok;
    ack_delay = 2;
    @(negedge CLK);
    exp_q.push_back(txn_t'{dm: 1'b0, addr: 32'h100, wdata: 32'h0, rw: RW_LW, rdata: 32'h13});
    if_cmd_q.push_back(32'h100);
    wait_drain(60, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL single_fetch_drain: ok=%0d expected 1", ok);
    end
    repeat (2) @(negedge CLK);
    tests_run++;
    if (IF_RDATA !== 32'h13) begin
      tests_failed++;
      $display("FAIL single_fetch_hold: IF_RDATA=%h expected 00000013", IF_RDATA);
    end
  endtask

  task automatic test_latency();
    bit ok;
    int lat;
    logic req_n1;
    ack_delay = 0;
    lat = -1;
    req_n1 = 1'b0;
    @(negedge CLK);
    exp_q.push_back(txn_t'{dm: 1'b0, addr: 32'h200, wdata: 32'h0, rw: RW_LW, rdata: mem_word(32'h200)});
    if_cmd_q.push_back(32'h200);
    for (int i = 0; i < 5 && !IF_REQ; i++) @(negedge CLK);
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (i == 1) req_n1 = MEM_REQ;
      if (IF_READY) begin
        lat = i;
        break;
      end
    end
    tests_run++;
    if (req_n1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL latency_mem_req: MEM_REQ one cycle after request=%b expected 1", req_n1);
    end
    tests_run++;
    if (lat != 2) begin
      tests_failed++;
      $display("FAIL latency_ready: cycles to IF_READY=%0d expected 2", lat);
    end
    wait_drain(20, ok);
  endtask

  task automatic test_dm_null();
    bit ok;
    @(negedge CLK);
    dm_resp_q.push_back(32'h0);
    dm_cmd_q.push_back(dm_cmd_t'{addr: 32'h44, wdata: 32'h0, rw: RW_NONE});
    for (int i = 0; i < 5 && !DM_REQ; i++) @(negedge CLK);
    @(negedge CLK);
    tests_run++;
    if ({DM_READY, MEM_REQ} !== 2'b10) begin
      tests_failed++;
      $display("FAIL dm_null: DM_READY,MEM_REQ=%b expected 10", {DM_READY, MEM_REQ});
    end
    wait_drain(20, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL dm_null_drain: ok=%0d expected 1", ok);
    end
  endtask

  task automatic test_conflict();
    bit ok;
    int cyc, dm_rdy_cyc, if_req_cyc, rises, stall_gaps;
    logic prev;
    logic stall_at_ready;
    apply_reset();
    ack_delay = 1;
    cyc = 0; dm_rdy_cyc = -10; if_req_cyc = -1; rises = 0; stall_gaps = 0;
    prev = 1'b0; stall_at_ready = 1'b1;
    exp_q.push_back(txn_t'{dm: 1'b1, addr: 32'h2000, wdata: 32'h0, rw: 4'b0010, rdata: mem_word(32'h2000)});
    exp_q.push_back(txn_t'{dm: 1'b0, addr: 32'h300, wdata: 32'h0, rw: RW_LW, rdata: mem_word(32'h300)});
    dm_cmd_q.push_back(dm_cmd_t'{addr: 32'h2000, wdata: 32'h0, rw: 4'b0010});
    if_cmd_q.push_back(32'h300);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      cyc++;
      if (MEM_REQ && !prev) begin
        rises++;
        if (rises == 2) if_req_cyc = cyc;
      end
      prev = MEM_REQ;
      if (DM_READY) dm_rdy_cyc = cyc;
      if (IF_READY) begin
        stall_at_ready = STALL_IF;
        break;
      end
      if (IF_REQ && !STALL_IF) stall_gaps++;
    end
    tests_run++;
    if (if_req_cyc != dm_rdy_cyc + 1) begin
      tests_failed++;
      $display("FAIL conflict_if_after_dm: IF MEM_REQ cycle=%0d expected %0d", if_req_cyc, dm_rdy_cyc + 1);
    end
    tests_run++;
    if (stall_gaps != 0 || stall_at_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL conflict_stall_if: low cycles=%0d at_ready=%b expected 0 and 0", stall_gaps, stall_at_ready);
    end
    wait_drain(30, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL conflict_drain: ok=%0d expected 1", ok);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    apply_reset();
    ack_delay = 0;
    exp_q.push_back(txn_t'{dm: 1'b1, addr: 32'h2100, wdata: 32'h0, rw: 4'b0010, rdata: mem_word(32'h2100)});
    exp_q.push_back(txn_t'{dm: 1'b0, addr: 32'h400, wdata: 32'h0, rw: RW_LW, rdata: mem_word(32'h400)});
    exp_q.push_back(txn_t'{dm: 1'b1, addr: 32'h2104, wdata: 32'h0, rw: 4'b0010, rdata: mem_word(32'h2104)});
    exp_q.push_back(txn_t'{dm: 1'b0, addr: 32'h404, wdata: 32'h0, rw: RW_LW, rdata: mem_word(32'h404)});
    dm_cmd_q.push_back(dm_cmd_t'{addr: 32'h2100, wdata: 32'h0, rw: 4'b0010});
    dm_cmd_q.push_back(dm_cmd_t'{addr: 32'h2104, wdata: 32'h0, rw: 4'b0010});
    if_cmd_q.push_back(32'h400);
    if_cmd_q.push_back(32'h404);
    wait_drain(80, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL back_to_back_drain: ok=%0d expected 1 (remaining grants=%0d)", ok, exp_q.size());
    end
  endtask

  task automatic test_store();
    bit ok;
    ack_delay = 3;
    @(negedge CLK);
    exp_q.push_back(txn_t'{dm: 1'b1, addr: 32'h40, wdata: 32'hDEADBEEF, rw: 4'b1111, rdata: 32'h0});
    dm_cmd_q.push_back(dm_cmd_t'{addr: 32'h40, wdata: 32'hDEADBEEF, rw: 4'b1111});
    wait_drain(40, ok);
    tests_run++;
    if (!ok || DM_RDATA !== 32'h0) begin
      tests_failed++;
      $display("FAIL store: ok=%0d DM_RDATA=%h expected 1 and 00000000", ok, DM_RDATA);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    resp_en = 1'b0;
    seen = 1'b0;
    @(negedge CLK);
    exp_q.push_back(txn_t'{dm: 1'b1, addr: 32'h3000, wdata: 32'h0, rw: 4'b0010, rdata: mem_word(32'h3000)});
    dm_cmd_q.push_back(dm_cmd_t'{addr: 32'h3000, wdata: 32'h0, rw: 4'b0010});
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (MEM_REQ) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL reset_mid_grant: MEM_REQ seen=%0d expected 1", seen);
    end
    RESET = 1'b1;
    flush = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    flush = 1'b0;
    force_ack = 1'b1;
    dm_resp_q.delete();
    tests_run++;
    if (MEM_REQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_drop: MEM_REQ=%b expected 0", MEM_REQ);
    end
    @(negedge CLK);
    force_ack = 1'b0;
    tests_run++;
    if ({MEM_REQ, DM_READY} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_mid_late_ack: MEM_REQ,DM_READY=%b expected 00", {MEM_REQ, DM_READY});
    end
    @(negedge CLK);
    tests_run++;
    if ({MEM_REQ, DM_READY, IF_RDATA} !== 34'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_idle: MEM_REQ=%b DM_READY=%b IF_RDATA=%h expected 0 0 0", MEM_REQ, DM_READY, IF_RDATA);
    end
    resp_en = 1'b1;
    ack_delay = 0;
    // Arbitration history must be back to its reset value: data wins the conflict.
    exp_q.push_back(txn_t'{dm: 1'b1, addr: 32'h3100, wdata: 32'h0, rw: 4'b0010, rdata: mem_word(32'h3100)});
    exp_q.push_back(txn_t'{dm: 1'b0, addr: 32'h500, wdata: 32'h0, rw: RW_LW, rdata: mem_word(32'h500)});
    dm_cmd_q.push_back(dm_cmd_t'{addr: 32'h3100, wdata: 32'h0, rw: 4'b0010});
    if_cmd_q.push_back(32'h500);
    wait_drain(40, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL reset_mid_recover: ok=%0d expected 1", ok);
    end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int lat, early_err;
    logic err_at_ready, err_after;
    lat = -1; early_err = 0; err_at_ready = 1'b0; err_after = 1'b1;
    timeout_mode = 1'b1;
    resp_en = 1'b0;
    @(negedge CLK);
    exp_q.push_back(txn_t'{dm: 1'b1, addr: 32'h5000, wdata: 32'h0, rw: 4'b0010, rdata: 32'h0});
    dm_cmd_q.push_back(dm_cmd_t'{addr: 32'h5000, wdata: 32'h0, rw: 4'b0010});
    for (int i = 0; i < 10 && !MEM_REQ; i++) @(negedge CLK);
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (DM_READY) begin
        lat = i;
        err_at_ready = ERR;
        break;
      end
      if (ERR) early_err++;
    end
    @(negedge CLK);
    err_after = ERR;
    tests_run++;
    if (lat != 4) begin
      tests_failed++;
      $display("FAIL timeout_latency: DM_READY %0d cycles after MEM_REQ, expected 4", lat);
    end
    tests_run++;
    if (err_at_ready !== 1'b1 || err_after !== 1'b0 || early_err != 0) begin
      tests_failed++;
      $display("FAIL timeout_err: at_ready=%b after=%b early=%0d expected 1 0 0", err_at_ready, err_after, early_err);
    end
    timeout_mode = 1'b0;
    resp_en = 1'b1;
    wait_drain(20, ok);
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    int readies;
    readies = 0;
    resp_en = 1'b0;
    @(negedge CLK);
    exp_q.push_back(txn_t'{dm: 1'b1, addr: 32'h6000, wdata: 32'h0, rw: 4'b0010, rdata: mem_word(32'h6000)});
    dm_cmd_q.push_back(dm_cmd_t'{addr: 32'h6000, wdata: 32'h0, rw: 4'b0010});
    repeat (80) begin
      @(negedge CLK);
      if (DM_READY) readies++;
    end
    tests_run++;
    if (readies != 0 || MEM_REQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL no_timeout_wait: readies=%0d MEM_REQ=%b expected 0 and 1", readies, MEM_REQ);
    end
    resp_en = 1'b1;
    wait_drain(20, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL no_timeout_drain: ok=%0d expected 1", ok);
    end
  endtask
`endif

  initial begin
    RESET = 1'b1;
    test_reset();
    test_single_fetch();
    test_latency();
    test_dm_null();
    test_conflict();
    test_back_to_back();
    test_store();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
